// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and memory geometry for the memory arbiter
package mem_arb_pkg;

  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 32;
  localparam int MEM_DEPTH = 50;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef enum logic {PORT_F = 1'b0, PORT_D = 1'b1} port_e;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rtl/mem_arbiter_rr_arb2.sv - two-requester round-robin pick (combinational)
module rr_arb2 (
  input  logic req_f,
  input  logic req_d,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);
  import mem_arb_pkg::*;

  always_comb begin
    gnt_valid = req_f | req_d;
    // On a tie the port that did not win last time goes first
    if (req_f && req_d) begin
      gnt_id = ~last_grant;
    end else if (req_f) begin
      gnt_id = PORT_F;
    end else begin
      gnt_id = PORT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/load-store sequencer for the single-ported unified memory
module mem_arbiter #(
  parameter int ADDR_W    = mem_arb_pkg::ADDR_W,
  parameter int DATA_W    = mem_arb_pkg::DATA_W,
  parameter int MEM_DEPTH = mem_arb_pkg::MEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_ack,
  output logic              f_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_memwrite,
  output logic              mem_memread,
  input  logic [DATA_W-1:0] mem_out32,
  output logic              busy
);
  import mem_arb_pkg::*;

  state_e            state_q, state_d;
  port_e             gnt_q, last_q, gnt_id;
  logic              gnt_valid, gnt_raw;
  logic [ADDR_W-1:0] addr_q, sel_addr;
  logic              we_q, oor_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;

  rr_arb2 u_rr (
    .req_f      (f_req),
    .req_d      (d_req),
    .last_grant (last_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_raw)
  );

  assign gnt_id   = port_e'(gnt_raw);
  assign sel_addr = (gnt_id == PORT_F) ? f_addr : d_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_valid) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request snapshot taken at grant; the memory cycle then runs purely from these registers
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q   <= PORT_F;
      last_q  <= PORT_D;
      addr_q  <= '0;
      we_q    <= 1'b0;
      oor_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == IDLE && gnt_valid) begin
        gnt_q   <= gnt_id;
        addr_q  <= sel_addr;
        we_q    <= (gnt_id == PORT_D) && d_we;
        wdata_q <= d_wdata;
        oor_q   <= {1'b0, sel_addr} >= (ADDR_W + 1)'(MEM_DEPTH);
      end
      if (state_q == ACCESS) begin
        last_q  <= gnt_q;
        rdata_q <= (!we_q && !oor_q) ? mem_out32 : '0;
      end
    end
  end

  always_comb begin
    mem_address   = '0;
    mem_writeData = '0;
    mem_memwrite  = 1'b0;
    mem_memread   = 1'b0;
    f_ack         = 1'b0;
    f_err         = 1'b0;
    f_rdata       = '0;
    d_ack         = 1'b0;
    d_err         = 1'b0;
    d_rdata       = '0;
    busy          = (state_q != IDLE);
    case (state_q)
      ACCESS: begin
        mem_address = addr_q;
        if (!oor_q) begin
          mem_memread   = !we_q;
          mem_memwrite  = we_q;
          mem_writeData = we_q ? wdata_q : '0;
        end
      end
      RESP: begin
        if (gnt_q == PORT_F) begin
          f_ack   = 1'b1;
          f_err   = oor_q;
          f_rdata = rdata_q;
        end else begin
          d_ack   = 1'b1;
          d_err   = oor_q;
          d_rdata = rdata_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a behavioural memory
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        f_req = 1'b0;
  logic [5:0]  f_addr = '0;
  logic [31:0] f_rdata;
  logic        f_ack, f_err;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [5:0]  d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack, d_err;
  logic [5:0]  mem_address;
  logic [31:0] mem_writeData;
  logic        mem_memwrite, mem_memread;
  logic [31:0] mem_out32;
  logic        busy;

  logic        tb_load = 1'b1;
  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:63];
  bit          model_last;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_ack(f_ack), .f_err(f_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_out32(mem_out32), .busy(busy)
  );

  function automatic logic [31:0] init_word(int i);
    return (i == 0) ? 32'h00430822 : 32'h1000_0000 + 32'(i) * 32'h0101_0003;
  endfunction

  // Unified memory: combinational read, write at the rising edge
  always @(posedge clk) begin
    if (tb_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (mem_memwrite && mem_address < 6'd50) begin
      mem[mem_address] <= mem_writeData;
    end
  end
  assign mem_out32 = (mem_address < 6'd50) ? mem[mem_address] : 32'h0;

  // Reference: each completed access either errors, stores, or returns current contents
  task automatic model_txn(input bit port, input bit we, input logic [5:0] addr,
                           input logic [31:0] wd, output logic exp_err, output logic [31:0] exp_rd);
    exp_err = 1'b0;
    exp_rd  = 32'h0;
    if (addr >= 6'd50) exp_err = 1'b1;
    else if (port && we) ref_mem[addr] = wd;
    else exp_rd = ref_mem[addr];
    model_last = port;
  endtask

  task automatic do_txn(input bit port, input bit we, input logic [5:0] addr, input logic [31:0] wd,
                        output int lat, output logic err, output logic [31:0] rd,
                        output bit other, output bit wr_seen);
    lat = -1; err = 1'b0; rd = 32'h0; other = 1'b0; wr_seen = 1'b0;
    if (!port) begin
      f_req = 1'b1; f_addr = addr;
    end else begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
    end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_memwrite) wr_seen = 1'b1;
      if (port ? f_ack : d_ack) other = 1'b1;
      if (port ? d_ack : f_ack) begin
        lat = c - 1;
        err = port ? d_err : f_err;
        rd  = port ? d_rdata : f_rdata;
        break;
      end
    end
    f_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; tb_load = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; tb_load = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    model_last = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({busy, f_ack, d_ack, f_err, d_err, mem_memwrite, mem_memread} !== 7'b0 ||
        f_rdata !== 32'h0 || d_rdata !== 32'h0 || mem_address !== 6'h0 || mem_writeData !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b acks=%b%b mem_addr=%h got nonzero, required all 0",
               busy, f_ack, d_ack, mem_address);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fetch0;
    int lat; logic err; logic [31:0] rd; bit other, wr;
    do_txn(1'b0, 1'b0, 6'd0, 32'h0, lat, err, rd, other, wr);
    model_last = 1'b0;
    n_tests++;
    if (lat !== 2) begin n_fail++; $display("FAIL fetch0_latency: got %0d required 2", lat); end
    n_tests++;
    if (err !== 1'b0 || rd !== 32'h00430822) begin
      n_fail++; $display("FAIL fetch0_data: got err=%b rdata=%h required err=0 rdata=00430822", err, rd);
    end
    n_tests++;
    if (wr !== 1'b0 || other !== 1'b0) begin
      n_fail++; $display("FAIL fetch0_side: got memwrite_seen=%b d_ack_seen=%b required 0 0", wr, other);
    end
  endtask

  task automatic test_store_load;
    int lat; logic err; logic [31:0] rd; bit other, wr; logic ee; logic [31:0] er;
    model_txn(1'b1, 1'b1, 6'd5, 32'hDEADBEEF, ee, er);
    do_txn(1'b1, 1'b1, 6'd5, 32'hDEADBEEF, lat, err, rd, other, wr);
    n_tests++;
    if (lat !== 2 || err !== ee || rd !== er || wr !== 1'b1) begin
      n_fail++;
      $display("FAIL store5: got lat=%0d err=%b rdata=%h wr=%b required lat=2 err=%b rdata=%h wr=1",
               lat, err, rd, wr, ee, er);
    end
    model_txn(1'b1, 1'b0, 6'd5, 32'h0, ee, er);
    do_txn(1'b1, 1'b0, 6'd5, 32'h0, lat, err, rd, other, wr);
    n_tests++;
    if (lat !== 2 || err !== 1'b0 || rd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL load5: got lat=%0d err=%b rdata=%h required lat=2 err=0 rdata=deadbeef",
                         lat, err, rd);
    end
  endtask

  task automatic test_tie;
    int cyc[$]; bit prt[$]; bit dbl;
    logic ee; logic [31:0] er;
    reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
    model_last = 1'b1;
    dbl = 1'b0;
    f_req = 1'b1; f_addr = 6'd3; d_req = 1'b1; d_we = 1'b0; d_addr = 6'd9;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (f_ack && d_ack) dbl = 1'b1;
      if (f_ack) begin
        cyc.push_back(c); prt.push_back(1'b0);
        model_txn(1'b0, 1'b0, 6'd3, 32'h0, ee, er);
        n_tests++;
        if (f_rdata !== er) begin n_fail++; $display("FAIL tie_f_data: got %h required %h", f_rdata, er); end
      end
      if (d_ack) begin
        cyc.push_back(c); prt.push_back(1'b1);
        model_txn(1'b1, 1'b0, 6'd9, 32'h0, ee, er);
        n_tests++;
        if (d_rdata !== er) begin n_fail++; $display("FAIL tie_d_data: got %h required %h", d_rdata, er); end
      end
    end
    f_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (dbl || cyc.size() != 4) begin
      n_fail++; $display("FAIL tie_count: got %0d acks double=%b required 4 acks double=0", cyc.size(), dbl);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (prt[i] !== bit'(i % 2) || cyc[i] != 3 + 3 * i) begin
          n_fail++;
          $display("FAIL tie_order_%0d: got port=%0d cycle=%0d required port=%0d cycle=%0d",
                   i, prt[i], cyc[i], i % 2, 3 + 3 * i);
        end
      end
    end
  endtask

  task automatic test_out_of_range;
    int lat; logic err; logic [31:0] rd; bit other, wr; logic ee; logic [31:0] er;
    model_txn(1'b1, 1'b1, 6'd55, 32'h12345678, ee, er);
    do_txn(1'b1, 1'b1, 6'd55, 32'h12345678, lat, err, rd, other, wr);
    n_tests++;
    if (lat !== 2 || err !== 1'b1 || rd !== 32'h0 || wr !== 1'b0) begin
      n_fail++; $display("FAIL oor_store: got lat=%0d err=%b rdata=%h wr=%b required 2 1 0 0", lat, err, rd, wr);
    end
    model_txn(1'b1, 1'b0, 6'd55, 32'h0, ee, er);
    do_txn(1'b1, 1'b0, 6'd55, 32'h0, lat, err, rd, other, wr);
    n_tests++;
    if (err !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL oor_load: got err=%b rdata=%h required err=1 rdata=0", err, rd);
    end
    model_txn(1'b0, 1'b0, 6'd50, 32'h0, ee, er);
    do_txn(1'b0, 1'b0, 6'd50, 32'h0, lat, err, rd, other, wr);
    n_tests++;
    if (err !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL oor_fetch50: got err=%b rdata=%h required err=1 rdata=0", err, rd);
    end
  endtask

  task automatic test_reset_in_access;
    int lat; logic err; logic [31:0] rd; bit other, wr;
    logic [31:0] val;
    val = 32'hC0DE_0007;
    d_req = 1'b1; d_we = 1'b1; d_addr = 6'd7; d_wdata = val;
    @(posedge clk); #1;
    reset = 1'b1; d_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem_memwrite !== 1'b1 || mem_address !== 6'd7) begin
      n_fail++; $display("FAIL rst_access_drive: got memwrite=%b addr=%0d required 1 7", mem_memwrite, mem_address);
    end
    @(posedge clk); #1 reset = 1'b0;
    ref_mem[7] = val;
    model_last = 1'b1;
    @(negedge clk);
    n_tests++;
    if (d_ack !== 1'b0 || busy !== 1'b0 || mem[7] !== val) begin
      n_fail++; $display("FAIL rst_access_after: got d_ack=%b busy=%b mem7=%h required 0 0 %h", d_ack, busy, mem[7], val);
    end
    @(posedge clk); #1;
    do_txn(1'b0, 1'b0, 6'd7, 32'h0, lat, err, rd, other, wr);
    model_last = 1'b0;
    n_tests++;
    if (lat !== 2 || err !== 1'b0 || rd !== val) begin
      n_fail++; $display("FAIL rst_access_fetch7: got lat=%0d err=%b rdata=%h required 2 0 %h", lat, err, rd, val);
    end
  endtask

  task automatic test_random;
    int lat; logic err; logic [31:0] rd; bit other, wr; logic ee; logic [31:0] er;
    bit port, we, winner, got_f, got_d, first_set, first;
    logic [5:0] addr, fa, da;
    logic [31:0] wd;
    for (int it = 0; it < 60; it++) begin
      addr = 6'($urandom_range(0, 63));
      wd   = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        port = 1'($urandom_range(0, 1));
        we   = port & 1'($urandom_range(0, 1));
        model_txn(port, we, addr, wd, ee, er);
        do_txn(port, we, addr, wd, lat, err, rd, other, wr);
        n_tests++;
        if (lat !== 2 || err !== ee || rd !== er || other || wr !== (we && addr < 6'd50)) begin
          n_fail++;
          $display("FAIL rand_single_%0d: port=%0d we=%0d addr=%0d got lat=%0d err=%b rdata=%h wr=%b other=%b required 2 %b %h %b 0",
                   it, port, we, addr, lat, err, rd, wr, other, ee, er, we && addr < 6'd50);
        end
      end else begin
        fa = addr; da = 6'($urandom_range(0, 63)); we = 1'($urandom_range(0, 1));
        winner = ~model_last;
        got_f = 1'b0; got_d = 1'b0; first_set = 1'b0; first = 1'b0;
        f_req = 1'b1; f_addr = fa; d_req = 1'b1; d_we = we; d_addr = da; d_wdata = wd;
        for (int c = 1; c <= 10 && !(got_f && got_d); c++) begin
          @(negedge clk);
          if (f_ack && !got_f) begin
            got_f = 1'b1; f_req = 1'b0;
            if (!first_set) begin first = 1'b0; first_set = 1'b1; end
            model_txn(1'b0, 1'b0, fa, 32'h0, ee, er);
            n_tests++;
            if (f_err !== ee || f_rdata !== er || d_ack) begin
              n_fail++; $display("FAIL rand_tie_f_%0d: got err=%b rdata=%h d_ack=%b required %b %h 0",
                                 it, f_err, f_rdata, d_ack, ee, er);
            end
          end else if (d_ack && !got_d) begin
            got_d = 1'b1; d_req = 1'b0;
            if (!first_set) begin first = 1'b1; first_set = 1'b1; end
            model_txn(1'b1, we, da, wd, ee, er);
            n_tests++;
            if (d_err !== ee || d_rdata !== er || f_ack) begin
              n_fail++; $display("FAIL rand_tie_d_%0d: got err=%b rdata=%h f_ack=%b required %b %h 0",
                                 it, d_err, d_rdata, f_ack, ee, er);
            end
          end
        end
        f_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (!(got_f && got_d) || first !== winner) begin
          n_fail++; $display("FAIL rand_tie_order_%0d: got acks f=%b d=%b first=%0d required both, first=%0d",
                             it, got_f, got_d, first, winner);
        end
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_fetch0;
    test_store_load;
    test_tie;
    test_out_of_range;
    test_reset_in_access;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the single-ported 50-word unified instruction/data memory of the multicycle MIPS core. It shares the memory between the instruction-fetch requester (read-only) and the load/store requester using round-robin arbitration. It drives the memory's address, write-data, write-enable and read-enable inputs, and returns registered read data with a one-cycle acknowledge. Every memory access in the core goes through this block.

## Interface
Parameters:
- ADDR_W, 6, word-address width of the memory
- DATA_W, 32, data width
- MEM_DEPTH, 50, number of implemented words; addresses >= MEM_DEPTH are out of range

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- f_req  in  1  fetch request; held until f_ack
- f_addr  in  ADDR_W  fetch word address; stable while f_req=1
- f_rdata  out  DATA_W  fetch read data; valid only while f_ack=1
- f_ack  out  1  one-cycle completion pulse for fetch
- f_err  out  1  qualifies f_ack: address out of range
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load; stable while d_req=1
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data; valid only while d_ack=1
- d_ack  out  1  one-cycle completion pulse for data
- d_err  out  1  qualifies d_ack: address out of range
- mem_address  out  ADDR_W  to memory address
- mem_writeData  out  DATA_W  to memory writeData
- mem_memwrite  out  1  to memory memwrite
- mem_memread  out  1  to memory memread
- mem_out32  in  DATA_W  from memory out32 (combinational read)
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the port opposite last_grant.
  - On a grant: latch grant id, addr, we, wdata and range flag (addr >= MEM_DEPTH), then go to ACCESS.
- ACCESS (one cycle), outputs driven from the latched registers:
  - In range, read: mem_memread=1. mem_out32 is captured into the read-data register at the ending edge.
  - In range, write: mem_memwrite=1, mem_writeData=wdata. The write commits at the ending edge. The read-data register is cleared to 0.
  - Out of range: memwrite=0, memread=0, read-data register cleared to 0.
  - Update last_grant to the granted port. Go to RESP.
- RESP (one cycle):
  - Assert the granted port's ack, with err equal to the range flag. That port's rdata shows the read-data register.
  - The other port's ack, err and rdata are 0.
  - Go to IDLE.
- Fetch is always a read. Fetch never asserts mem_memwrite.
- mem_address holds the latched address in ACCESS and is 0 otherwise. mem_memread and mem_memwrite are 0 outside ACCESS.
- Requests that arrive while busy wait. They are sampled in the next IDLE cycle.
- A request dropped before its ack is a protocol violation. The transaction completes anyway.

## Timing
- All outputs are registered or decoded from registered state. There are no combinational paths from request inputs to outputs.
- A request sampled high at the IDLE edge ending cycle N produces:
  - ACCESS in cycle N+1
  - ack in cycle N+2
  - IDLE in cycle N+3
- Latency from request to ack is 2 cycles. Maximum throughput is one access per 3 cycles.
- Requester rule: deassert req, or present the next request, at the edge ending the ack cycle. The arbiter samples again at the edge ending N+3.
- Reset values:
  - state=IDLE, last_grant=DATA (so the first tie goes to fetch)
  - all acks, errs, rdata, mem_* outputs and busy = 0
- Reset asserted during ACCESS: a write already driven in that cycle still commits at that edge. No ack is issued, and the state returns to IDLE.
- Reset asserted during RESP: the ack in that cycle is still seen. Next state is IDLE.
- Starvation bound: with both ports requesting continuously, grants alternate F, D, F, D. Each port waits at most 6 cycles for its ack.

## Structure
- Shared package mem_arb_pkg:
  - state enum {IDLE, ACCESS, RESP}
  - port-id enum {PORT_F, PORT_D}
  - constants ADDR_W, DATA_W, MEM_DEPTH, shared with the memory block
- Sub-module rr_arb2:
  - combinational two-requester round-robin pick
  - inputs: req_f, req_d, last_grant; outputs: gnt_valid, gnt_id
- The FSM, latch registers and output decode live in mem_arbiter.
- The bench instantiates mem_arbiter together with the existing memory block.

## Test plan
- Reset, then f_req=1, f_addr=0: ack 2 cycles later, f_ack=1, f_err=0, f_rdata=32'h00430822; mem_memwrite stays 0 throughout.
- d_req=1, d_we=1, d_addr=5, d_wdata=32'hDEADBEEF, then a load from address 5: store d_ack after 2 cycles; load returns d_rdata=32'hDEADBEEF.
- f_req and d_req asserted in the same cycle right after reset, held continuously: acks in order F, D, F, D at 3-cycle spacing; no double ack in any cycle.
- d_addr=55, d_we=1: d_ack=1 with d_err=1 and d_rdata=0; mem_memwrite never asserts; a following read of address 55 also returns err.
- Reset asserted in the ACCESS cycle of a store to address 7: the value is written, no d_ack appears, busy=0 next cycle; a following fetch from address 7 succeeds.
